vreg_load_unit: RTL and testbench

Vector load unit for the interpolation ASIP. It fetches four consecutive 32-bit words from data memory, assembles them into one 128-bit vector, and commits the vector to the vector register file through its write port (WriteEn / rd / InputData). This is the writer side of the vector register file, whose decode stage reads through Rs1/Rs2. It sits between the memory stage and the register file and serves vector-load instructions.

---
 rtl/vreg_load_unit_if.sv | 44 ++++
 rtl/vreg_load_unit.sv | 162 ++++++++++++++++
 tb/tb_vreg_load_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vreg_load_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : vreg_load_unit_if
//  Purpose  : Bundles the request, memory-read and register-file write
//             signals of the vector load unit.
//             slave  modport : view of the load unit itself
//             master modport : view of the surrounding pipeline / memory
//  Signals  : start, base_addr, rd_in           - load request
//             mem_rd_en, mem_addr, mem_rdata,
//             mem_valid                         - data-memory read port
//             WriteEn, rd, InputData            - vector RF write port
//             busy, done, err                   - status
//  Revision : 1.0  initial release
// ============================================================================
interface vreg_load_unit_if #(
   parameter int WORD_W = 32,
   parameter int VEC_W  = 128,
   parameter int ADDR_W = 32
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [4:0]        rd_in;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_rdata;
   logic              mem_valid;
   logic              WriteEn;
   logic [4:0]        rd;
   logic [VEC_W-1:0]  InputData;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, base_addr, rd_in, mem_rdata, mem_valid,
      input  mem_rd_en, mem_addr, WriteEn, rd, InputData, busy, done, err
   );

   modport slave (
      input  start, base_addr, rd_in, mem_rdata, mem_valid,
      output mem_rd_en, mem_addr, WriteEn, rd, InputData, busy, done, err
   );
endinterface
`default_nettype wire

// File: rtl/vreg_load_unit.sv
`default_nettype none
// ============================================================================
//  Module   : vreg_load_unit
//  Purpose  : Vector load unit. Reads four consecutive 32-bit words from data
//             memory (base, base+4, base+8, base+12), packs them lane 0 at
//             the LSBs into one 128-bit vector and writes it to the vector
//             register file with a single WriteEn pulse.
//  Ports    : clk    - clock, rising edge
//             rst_n  - asynchronous active-low reset
//             io_bus - vreg_load_unit_if.slave (request, memory, RF, status)
//  Options  : VLOAD_TIMEOUT_EN - when defined, a WAIT beat that sees no
//             mem_valid for TIMEOUT cycles aborts the load with an err pulse.
//             When undefined, err is tied low and WAIT holds indefinitely.
//  Revision : 1.0  initial release
// ============================================================================
module vreg_load_unit #(
   parameter int WORD_W  = 32,
   parameter int VEC_W   = 128,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   vreg_load_unit_if.slave    io_bus
);

   if (VEC_W != 4 * WORD_W || ADDR_W < 4 || TIMEOUT < 1) begin : g_bad_cfg
      $error("vreg_load_unit: inconsistent parameters");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   state_t            r_state;
   logic [1:0]        r_beat;
   logic [ADDR_W-1:0] r_base;
   logic              r_mem_rd_en;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_we;
   logic              r_done;
   logic              r_busy;
   logic [4:0]        r_rd;
   logic [VEC_W-1:0]  r_vec;

   logic [1:0]        w_beat_nxt;
   logic [ADDR_W-1:0] w_next_addr;

   // Address of the next beat; the adder wraps naturally modulo 2^ADDR_W.
   assign w_beat_nxt  = r_beat + 2'd1;
   assign w_next_addr = r_base + {{(ADDR_W-4){1'b0}}, w_beat_nxt, 2'b00};

`ifdef VLOAD_TIMEOUT_EN
   localparam int                 c_CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
   logic [c_CNT_W-1:0] r_wait_cnt;
   logic               r_err;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_beat      <= 2'd0;
         r_base      <= '0;
         r_mem_rd_en <= 1'b0;
         r_mem_addr  <= '0;
         r_we        <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_rd        <= 5'd0;
         r_vec       <= '0;
`ifdef VLOAD_TIMEOUT_EN
         r_wait_cnt  <= '0;
         r_err       <= 1'b0;
`endif
      end else begin
         // Strobes are single-cycle; they are only raised on the transition
         // into the state where they must be visible.
         r_mem_rd_en <= 1'b0;
         r_we        <= 1'b0;
         r_done      <= 1'b0;
`ifdef VLOAD_TIMEOUT_EN
         r_err       <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (io_bus.start) begin
                  r_state     <= S_REQ;
                  r_base      <= io_bus.base_addr;
                  r_rd        <= io_bus.rd_in;
                  r_beat      <= 2'd0;
                  r_mem_rd_en <= 1'b1;
                  r_mem_addr  <= io_bus.base_addr;
                  r_busy      <= 1'b1;
               end
            end

            S_REQ: begin
               r_state <= S_WAIT;
`ifdef VLOAD_TIMEOUT_EN
               r_wait_cnt <= '0;
`endif
            end

            S_WAIT: begin
               if (io_bus.mem_valid) begin
                  r_vec[WORD_W*r_beat +: WORD_W] <= io_bus.mem_rdata;
                  if (r_beat == 2'd3) begin
                     r_state <= S_WRITE;
                     r_we    <= 1'b1;
                     r_done  <= 1'b1;
                  end else begin
                     r_state     <= S_REQ;
                     r_beat      <= w_beat_nxt;
                     r_mem_rd_en <= 1'b1;
                     r_mem_addr  <= w_next_addr;
                  end
               end
`ifdef VLOAD_TIMEOUT_EN
               // The TIMEOUT-th empty WAIT cycle aborts; valid data in that
               // same cycle takes the branch above instead.
               else if (r_wait_cnt == c_CNT_LAST) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_err   <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
`endif
            end

            S_WRITE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign io_bus.mem_rd_en = r_mem_rd_en;
   assign io_bus.mem_addr  = r_mem_addr;
   assign io_bus.WriteEn   = r_we;
   assign io_bus.done      = r_done;
   assign io_bus.busy      = r_busy;
   assign io_bus.rd        = r_rd;
   assign io_bus.InputData = r_vec;
`ifdef VLOAD_TIMEOUT_EN
   assign io_bus.err       = r_err;
`else
   assign io_bus.err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vreg_load_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vreg_load_unit
//  Purpose  : Self-checking bench for vreg_load_unit. Loads are issued from a
//             directed sequence; expected writes and read addresses go into
//             queues that independent monitors pop and compare.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vreg_load_unit;
   localparam int WORD_W  = 32;
   localparam int VEC_W   = 128;
   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vreg_load_unit_if #(.WORD_W(WORD_W), .VEC_W(VEC_W), .ADDR_W(ADDR_W)) bus ();

   vreg_load_unit #(
      .WORD_W (WORD_W),
      .VEC_W  (VEC_W),
      .ADDR_W (ADDR_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io_bus(bus)
   );

   typedef struct {
      logic [4:0]   rd;
      logic [127:0] data;
   } wr_t;

   wr_t         sb[$];
   logic [31:0] aq[$];
   int          total = 0;
   int          bad   = 0;
   int          n_we  = 0;
   int          lat[4];
   logic [31:0] mdata[4];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Memory model: answers a read strobe lat[beat] cycles later; 0 = never.
   initial begin : p_mem
      int pend;
      int mbeat;
      logic [31:0] d;
      pend = 0;
      mbeat = 0;
      d = '0;
      bus.mem_valid = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_valid = 1'b0;
         if (!rst_n || !bus.busy) begin
            pend  = 0;
            mbeat = 0;
         end
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               bus.mem_valid = 1'b1;
               bus.mem_rdata = d;
            end
         end
         if (bus.mem_rd_en) begin
            pend  = lat[mbeat];
            d     = mdata[mbeat];
            mbeat = (mbeat + 1) % 4;
         end
      end
   end

   // Read-address monitor.
   initial begin : p_amon
      logic [31:0] ea;
      forever begin
         @(posedge clk);
         #2;
         if (rst_n && bus.mem_rd_en) begin
            if (aq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL mem_addr_unexpected: got %h required no read", bus.mem_addr);
            end else begin
               ea = aq.pop_front();
               chk("mem_addr", bus.mem_addr, ea);
            end
         end
      end
   end

   // Register-file write monitor.
   initial begin : p_wmon
      wr_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.WriteEn) begin
            n_we++;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL write_unexpected: got rd=%0d data=%h required no write",
                        bus.rd, bus.InputData);
            end else begin
               e = sb.pop_front();
               chk("write_rd", bus.rd, e.rd);
               chk("write_data", bus.InputData, e.data);
               chk("write_done", bus.done, 1'b1);
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_mem_rd_en"}, bus.mem_rd_en, 1'b0);
      chk({tag, "_mem_addr"},  bus.mem_addr, 32'h0);
      chk({tag, "_WriteEn"},   bus.WriteEn, 1'b0);
      chk({tag, "_rd"},        bus.rd, 5'd0);
      chk({tag, "_InputData"}, bus.InputData, 128'h0);
      chk({tag, "_busy"},      bus.busy, 1'b0);
      chk({tag, "_done"},      bus.done, 1'b0);
      chk({tag, "_err"},       bus.err, 1'b0);
   endtask

   // One load; inj_cyc injects an ignored start, rst_cyc resets mid-load.
   task automatic run_load(input logic [31:0] base, input logic [4:0] r,
                           input int exp_cyc, input int inj_cyc, input int rst_cyc);
      int k;
      int we0;
      logic [127:0] ev;
      we0 = n_we;
      ev  = {mdata[3], mdata[2], mdata[1], mdata[0]};
      @(negedge clk);
      bus.start = 1'b1;
      bus.base_addr = base;
      bus.rd_in = r;
      sb.push_back('{rd: r, data: ev});
      for (int i = 0; i < 4; i++) aq.push_back(base + 32'(4 * i));
      @(negedge clk);
      bus.start = 1'b0;
      bus.base_addr = '0;
      bus.rd_in = '0;
      for (k = 1; k <= 60; k++) begin
         if (k == inj_cyc) begin
            bus.start = 1'b1;
            bus.rd_in = 5'd7;
            bus.base_addr = 32'h900;
         end else if (k == inj_cyc + 1) begin
            bus.start = 1'b0;
            bus.rd_in = '0;
            bus.base_addr = '0;
         end
         if (k == rst_cyc) break;
         if (bus.WriteEn) break;
         @(negedge clk);
      end
      if (rst_cyc != 0) begin
         rst_n = 1'b0;
         #1;
         check_all_zero("midreset");
         sb.delete();
         aq.delete();
         @(negedge clk);
         rst_n = 1'b1;
         repeat (15) @(negedge clk);
         chk("midreset_no_write", n_we - we0, 0);
         chk("midreset_busy", bus.busy, 1'b0);
      end else begin
         chk("we_cycle", k, exp_cyc);
         @(negedge clk);
         chk("busy_after_write", bus.busy, 1'b0);
         repeat (5) @(negedge clk);
         chk("we_count", n_we - we0, 1);
         chk("data_hold", bus.InputData, ev);
      end
   endtask

   initial begin : p_watchdog
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin : p_main
      bus.start = 1'b0;
      bus.base_addr = '0;
      bus.rd_in = '0;
      for (int i = 0; i < 4; i++) lat[i] = 1;
      mdata[0] = 32'h0; mdata[1] = 32'h0; mdata[2] = 32'h0; mdata[3] = 32'h0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", bus.busy, 1'b0);

      // Nominal load, 1-cycle memory.
      mdata[0] = 32'h11111111; mdata[1] = 32'h22222222;
      mdata[2] = 32'h33333333; mdata[3] = 32'h44444444;
      run_load(32'h100, 5'd5, 9, 0, 0);
      chk("nominal_vec", bus.InputData, 128'h44444444_33333333_22222222_11111111);

      // Beat 2 takes three cycles.
      mdata[0] = 32'hA0A0A0A0; mdata[1] = 32'hB1B1B1B1;
      mdata[2] = 32'hC2C2C2C2; mdata[3] = 32'hD3D3D3D3;
      lat[2] = 3;
      run_load(32'h200, 5'd12, 11, 0, 0);
      chk("varlat_vec", bus.InputData, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);
      lat[2] = 1;

      // start pulsed during WAIT of beat 1 is ignored.
      mdata[0] = 32'h01234567; mdata[1] = 32'h89ABCDEF;
      mdata[2] = 32'hFEDCBA98; mdata[3] = 32'h76543210;
      run_load(32'h100, 5'd5, 9, 4, 0);

      // Address wrap past 2^32.
      mdata[0] = 32'hDEADBEEF; mdata[1] = 32'hCAFEF00D;
      mdata[2] = 32'h0BADC0DE; mdata[3] = 32'h8BADF00D;
      run_load(32'hFFFF_FFF8, 5'd31, 9, 0, 0);

      // Reset during WAIT of beat 2, then a normal load.
      mdata[0] = 32'h5A5A5A5A; mdata[1] = 32'hA5A5A5A5;
      mdata[2] = 32'h3C3C3C3C; mdata[3] = 32'hC3C3C3C3;
      run_load(32'h300, 5'd9, 0, 0, 6);
      mdata[0] = 32'h10203040; mdata[1] = 32'h50607080;
      mdata[2] = 32'h90A0B0C0; mdata[3] = 32'hD0E0F000;
      run_load(32'h400, 5'd3, 9, 0, 0);
      chk("after_reset_vec", bus.InputData, 128'hD0E0F000_90A0B0C0_50607080_10203040);

`ifdef VLOAD_TIMEOUT_EN
      // Beat 1 never answered: err after TIMEOUT empty WAIT cycles.
      begin : b_timeout
         int k;
         int we0;
         we0 = n_we;
         lat[1] = 0;
         @(negedge clk);
         bus.start = 1'b1;
         bus.base_addr = 32'h500;
         bus.rd_in = 5'd4;
         aq.push_back(32'h500);
         aq.push_back(32'h504);
         @(negedge clk);
         bus.start = 1'b0;
         for (k = 1; k <= 60; k++) begin
            if (bus.err) break;
            @(negedge clk);
         end
         chk("timeout_err_cycle", k, 20);
         @(negedge clk);
         chk("timeout_err_pulse", bus.err, 1'b0);
         chk("timeout_busy", bus.busy, 1'b0);
         repeat (5) @(negedge clk);
         chk("timeout_no_write", n_we - we0, 0);
         lat[1] = 1;
      end
`endif

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      chk("aq_empty", aq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
